inst_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched entries, each carrying {esubcode, ecode, ex, inst, pc}, so decode back-pressure does not stall fetch immediately. It discards all contents on a pipeline flush (taken branch, exception or ertn). Once an entry carrying a fetch exception is accepted, it accepts nothing further until the next flush.

---
 rtl/inst_queue.sv | 99 +++++++++
 tb/tb_inst_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of DEPTH entries with wrap-bit pointers. A pipeline flush
// or reset discards all contents. After an entry with ex set is accepted, the
// queue refuses new entries until the next flush, but it keeps draining.
// Optional feature macro: IQ_BYPASS_EN. When it is defined, an empty queue
// forwards the fetch entry to decode in the same cycle.
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 72
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_iq_valid,
  input  logic [BUS_WD-1:0]          fs_to_iq_bus,
  output logic                       iq_allowin,
  output logic                       iq_to_ds_valid,
  output logic [BUS_WD-1:0]          iq_to_ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef enum logic {
    RUN     = 1'b0,
    EX_HOLD = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [BUS_WD-1:0]  mem [DEPTH];

  logic empty;
  logic full;
  logic q_pop;   // a stored entry leaves toward decode
  logic push;    // fetch handshake completes
  logic wr_en;   // entry is actually written into storage

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // Allowin only sees fetch valid through nothing; it depends on full/pop.
  assign q_pop      = ~empty && ~flush && ds_allowin;
  assign iq_allowin = ~reset && ~flush && (state_reg == RUN) && (~full || q_pop);
  assign push       = fs_to_iq_valid && iq_allowin;
  assign iq_count   = wr_ptr_reg - rd_ptr_reg;

`ifdef IQ_BYPASS_EN
  logic bypass;
  assign bypass         = empty && ~reset && ~flush && (state_reg == RUN);
  assign iq_to_ds_valid = bypass ? fs_to_iq_valid : (~empty && ~flush);
  assign iq_to_ds_bus   = bypass ? fs_to_iq_bus : mem[rd_ptr_reg[AW-1:0]];
  // A bypassed entry that decode takes immediately is never stored.
  assign wr_en          = push && ~(bypass && ds_allowin);
`else
  assign iq_to_ds_valid = ~empty && ~flush;
  assign iq_to_ds_bus   = mem[rd_ptr_reg[AW-1:0]];
  assign wr_en          = push;
`endif

  // Next pointers and state; flush clears everything and returns to RUN.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    state_next  = state_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      state_next  = RUN;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (q_pop) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && fs_to_iq_bus[64]) state_next = EX_HOLD;
    end
  end

  // Pointer and state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= RUN;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      state_reg  <= state_next;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= fs_to_iq_bus;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a reference model predicts allowin,
// valid, count and head; a scoreboard queue holds the expected entries.
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 72;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_to_iq_valid;
  logic [BUS_WD-1:0] fs_to_iq_bus;
  logic              iq_allowin;
  logic              iq_to_ds_valid;
  logic [BUS_WD-1:0] iq_to_ds_bus;
  logic              ds_allowin;
  logic              flush;
  logic [2:0]        iq_count;

  inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_iq_valid (fs_to_iq_valid),
    .fs_to_iq_bus   (fs_to_iq_bus),
    .iq_allowin     (iq_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [BUS_WD-1:0] sb[$];   // expected queue contents, head first
  logic              m_hold;  // model of the exception hold state

  task automatic chk(input string tag, input logic [BUS_WD-1:0] got,
                     input logic [BUS_WD-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic ex,
                                           input logic [5:0] ecode);
    return {1'b0, ecode, ex, ~pc, pc};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic v, input logic [BUS_WD-1:0] bus, input logic dsa,
                      input logic fl, input logic rst);
    logic exp_allow, exp_valid, byp, do_push, do_pop;
    int   n;
    reset = rst; fs_to_iq_valid = v; fs_to_iq_bus = bus;
    ds_allowin = dsa; flush = fl;
    #1;
    n = sb.size();
    exp_allow = !rst && !fl && !m_hold && (n < DEPTH || (dsa && n > 0));
`ifdef IQ_BYPASS_EN
    byp = !rst && !fl && !m_hold && (n == 0);
`else
    byp = 1'b0;
`endif
    exp_valid = byp ? v : (n > 0 && !fl);
    chk("allowin", {71'd0, iq_allowin}, {71'd0, exp_allow});
    if (!rst) begin
      chk("valid", {71'd0, iq_to_ds_valid}, {71'd0, exp_valid});
      chk("count", {69'd0, iq_count}, BUS_WD'(n));
      if (exp_valid) chk("head", iq_to_ds_bus, byp ? bus : sb[0]);
    end
    if (rst || fl) begin
      sb.delete();
      m_hold = 1'b0;
      $display("t=%0t %s", $time, rst ? "reset" : "flush");
    end else begin
      do_push = v && exp_allow;
      do_pop  = exp_valid && dsa;
      if (do_push && bus[64]) m_hold = 1'b1;
      if (do_push) $display("t=%0t push pc=%h ex=%b", $time, bus[31:0], bus[64]);
      if (do_pop)  $display("t=%0t pop  pc=%h", $time, iq_to_ds_bus[31:0]);
      if (!(byp && do_push && do_pop)) begin
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(bus);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    m_hold = 1'b0;
    reset = 1'b1; fs_to_iq_valid = 1'b0; fs_to_iq_bus = '0;
    ds_allowin = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Fill with decode stalled; the fifth push is refused.
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(32'h1c000000 + 32'(4 * i), 1'b0, 6'h0), 1'b0, 1'b0, 1'b0);
    chk("full_count", {69'd0, iq_count}, 72'd4);
    chk("full_allowin", {71'd0, iq_allowin}, 72'd0);
    chk("full_head", {40'd0, iq_to_ds_bus[31:0]}, 72'h1c000000);

    // Streaming on a full queue; pointers wrap past 2*DEPTH.
    pc = 32'h1c000010;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(pc, 1'b0, 6'h0), 1'b1, 1'b0, 1'b0);
      pc += 32'd4;
    end

    // Down to 3 entries, then flush while pushing 0x1c000100.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(32'h1c000100, 1'b0, 6'h0), 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fetch exception: accepted, then hold; entries drain; flush releases.
    step(1'b1, mk(32'h1c000200, 1'b0, 6'h0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(32'h1c000204, 1'b1, 6'h08), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(32'h1c000208 + 32'(4 * i), 1'b0, 6'h0), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(32'h1c000300, 1'b0, 6'h0), 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with two entries held.
    step(1'b1, mk(32'h1c000304, 1'b0, 6'h0), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Latency from an empty queue with decode ready.
    step(1'b1, mk(32'h1c000040, 1'b0, 6'h0), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    pc = 32'h1c001000;
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), mk(pc, ($urandom_range(0, 31) == 0), 6'h08),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
      pc += 32'd4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
